// File: rtl/prog_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prog_run_pkg
//  Brief    : Shared types and helpers for the program run controller:
//             FSM state encoding, select-width helper, entry address rule.
//  Revision : 1.0  initial release
// ============================================================================
package prog_run_pkg;

    // Run controller states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_t;

    // Width of the program select field: at least one bit even for NPROG=1
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Entry address of program `sel`: sel*stride truncated to `width` bits
    function automatic logic [31:0] entry_addr(input int unsigned sel,
                                               input int unsigned stride,
                                               input int unsigned width);
        logic [63:0] prod;
        logic [63:0] mask;
        prod = 64'(sel) * 64'(stride);
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return 32'(prod & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : prog_run_ctrl_if
//  Brief    : Handshake and PC-control bundle between the top-level pins,
//             the core decode and the run controller.
//  Revision : 1.0  initial release
// ============================================================================
interface prog_run_ctrl_if
    import prog_run_pkg::*;
#(
    parameter int D     = 12,
    parameter int NPROG = 3,
    parameter int W_CYC = 16
);
    localparam int SW = sel_width(NPROG);

    logic              req;
    logic [SW-1:0]     prog_sel;
    logic              halt;
    logic              pc_load;
    logic [D-1:0]      pc_target;
    logic              pc_en;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              bad_sel;
    logic [W_CYC-1:0]  cycles;

    // Requester / core side
    modport master (
        output req, prog_sel, halt,
        input  pc_load, pc_target, pc_en, busy, done, timeout, bad_sel, cycles
    );

    // Run controller side
    modport slave (
        input  req, prog_sel, halt,
        output pc_load, pc_target, pc_en, busy, done, timeout, bad_sel, cycles
    );

endinterface
`default_nettype wire

// File: rtl/prog_run_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : W-bit up counter with synchronous clear, enable and
//             saturation at all-ones.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          i_clr,
    input  wire          i_en,
    output logic [W-1:0] o_count
);
    localparam logic [W-1:0] c_max_count = '1;

    logic [W-1:0] r_count;

    // Count enabled cycles; clear wins over enable; hold at the maximum
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != c_max_count)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/prog_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : prog_run_ctrl
//  Brief    : Run controller: four-phase req/done handshake launching one of
//             NPROG programs, gating PC advance, ending on halt or timeout.
//  Revision : 1.0  initial release
// ============================================================================
module prog_run_ctrl
    import prog_run_pkg::*;
#(
    parameter int D           = 12,
    parameter int NPROG       = 3,
    parameter int PROG_STRIDE = 256,
    parameter int W_CYC       = 16,
    parameter int TIMEOUT     = 0
) (
    input wire              clk,
    input wire              reset,
    prog_run_ctrl_if.slave  bus
);
    localparam int SW = sel_width(NPROG);

    run_state_t        r_state;
    logic [SW-1:0]     r_sel;
    logic              r_timeout;
    logic              r_bad_sel;

    logic [W_CYC-1:0]  w_cycles;
    logic              w_sel_ok;
    logic              w_tmo_hit;
    logic              w_load;
    logic              w_cnt_en;
    logic [D-1:0]      w_entry;

    // Select is valid only below NPROG (relevant when NPROG is not a power of 2)
    assign w_sel_ok  = (32'(bus.prog_sel) < 32'(NPROG));
    // Cycle TIMEOUT of the run: counter still holds TIMEOUT-1 during it
    assign w_tmo_hit = (TIMEOUT != 0) && (32'(w_cycles) == (32'(TIMEOUT) - 32'd1));
    assign w_entry   = D'(entry_addr(32'(r_sel), PROG_STRIDE, D));
    assign w_load    = (r_state == LOAD);
    assign w_cnt_en  = (r_state == RUN);

    // Run sequencing: accept request, load entry, run, hold done until req drops
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_timeout <= 1'b0;
            r_bad_sel <= 1'b0;
        end else begin
            r_bad_sel <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req) begin
                        if (w_sel_ok) begin
                            r_sel   <= bus.prog_sel;
                            r_state <= LOAD;
                        end else begin
                            r_bad_sel <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    r_timeout <= 1'b0;
                    r_state   <= RUN;
                end
                RUN: begin
                    // Halt takes priority over a coincident timeout
                    if (bus.halt) begin
                        r_state <= DONE;
                    end else if (w_tmo_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.req) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sat_counter #(
        .W (W_CYC)
    ) u_cycle_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_load),
        .i_en    (w_cnt_en),
        .o_count (w_cycles)
    );

    assign bus.pc_load   = w_load;
    assign bus.pc_target = w_load ? w_entry : '0;
    // PC freezes on the halt instruction itself
    assign bus.pc_en     = (r_state == RUN) && !bus.halt;
    assign bus.busy      = (r_state == LOAD) || (r_state == RUN);
    assign bus.done      = (r_state == DONE);
    assign bus.timeout   = r_timeout;
    assign bus.bad_sel   = r_bad_sel;
    assign bus.cycles    = w_cycles;

endmodule
`default_nettype wire

// File: tb/tb_prog_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_run_ctrl
//  Brief    : Directed self-checking bench for prog_run_ctrl. Four instances
//             with different TIMEOUT / W_CYC share one stimulus; each test
//             checks the instance whose configuration it targets.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_run_ctrl;

    logic       clk;
    logic       r_reset;
    logic       r_req;
    logic [1:0] r_sel;
    logic       r_halt;

    int n_chk;
    int n_pass;

    prog_run_ctrl_if #(.D(12), .NPROG(3), .W_CYC(16)) if_a ();
    prog_run_ctrl_if #(.D(12), .NPROG(3), .W_CYC(16)) if_b ();
    prog_run_ctrl_if #(.D(12), .NPROG(3), .W_CYC(16)) if_c ();
    prog_run_ctrl_if #(.D(12), .NPROG(3), .W_CYC(3))  if_d ();

    assign if_a.req = r_req;  assign if_a.prog_sel = r_sel;  assign if_a.halt = r_halt;
    assign if_b.req = r_req;  assign if_b.prog_sel = r_sel;  assign if_b.halt = r_halt;
    assign if_c.req = r_req;  assign if_c.prog_sel = r_sel;  assign if_c.halt = r_halt;
    assign if_d.req = r_req;  assign if_d.prog_sel = r_sel;  assign if_d.halt = r_halt;

    prog_run_ctrl #(.D(12), .NPROG(3), .PROG_STRIDE(256), .W_CYC(16), .TIMEOUT(0))
        u_dut_a (.clk(clk), .reset(r_reset), .bus(if_a));
    prog_run_ctrl #(.D(12), .NPROG(3), .PROG_STRIDE(256), .W_CYC(16), .TIMEOUT(8))
        u_dut_b (.clk(clk), .reset(r_reset), .bus(if_b));
    prog_run_ctrl #(.D(12), .NPROG(3), .PROG_STRIDE(256), .W_CYC(16), .TIMEOUT(4))
        u_dut_c (.clk(clk), .reset(r_reset), .bus(if_c));
    prog_run_ctrl #(.D(12), .NPROG(3), .PROG_STRIDE(256), .W_CYC(3),  .TIMEOUT(0))
        u_dut_d (.clk(clk), .reset(r_reset), .bus(if_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        tick();
        r_reset = 1'b1; r_req = 1'b0; r_halt = 1'b0; r_sel = 2'd0;
        tick();
        tick();
        r_reset = 1'b0;
    endtask

    // Raise req with the given select; returns in the LOAD cycle
    task automatic launch(input logic [1:0] sel);
        tick();
        r_sel = sel; r_req = 1'b1;
        #1;
        tick();
        #1;
    endtask

    // Run n RUN cycles with halt asserted on the last; returns in first DONE cycle
    task automatic run_halt(input int n);
        for (int i = 1; i <= n; i++) begin
            tick();
            r_halt = (i == n);
            #1;
        end
        tick();
        r_halt = 1'b0;
        #1;
    endtask

    int  run_cnt;
    int  bad_cnt;
    logic seen;
    logic stray;

    initial begin
        n_chk = 0; n_pass = 0;
        r_reset = 1'b1; r_req = 1'b0; r_sel = 2'd0; r_halt = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick(); #1;
        chk("rst_busy",    32'(if_a.busy),    32'd0);
        chk("rst_done",    32'(if_a.done),    32'd0);
        chk("rst_pc_load", 32'(if_a.pc_load), 32'd0);
        chk("rst_pc_en",   32'(if_a.pc_en),   32'd0);
        chk("rst_bad_sel", 32'(if_a.bad_sel), 32'd0);
        chk("rst_cycles",  32'(if_a.cycles),  32'd0);
        chk("rst_timeout", 32'(if_a.timeout), 32'd0);
        r_reset = 1'b0;

        // ---------------- basic run, prog 1, halt on 5th RUN cycle ----------------
        tick();
        r_sel = 2'd1; r_req = 1'b1;
        #1;
        chk("basic_idle_load", 32'(if_a.pc_load), 32'd0);
        tick(); #1;
        chk("basic_pc_load",   32'(if_a.pc_load),   32'd1);
        chk("basic_target",    32'(if_a.pc_target), 32'h100);
        chk("basic_load_en",   32'(if_a.pc_en),     32'd0);
        chk("basic_load_busy", 32'(if_a.busy),      32'd1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            r_halt = (i == 5);
            #1;
            chk($sformatf("basic_pc_en_%0d", i), 32'(if_a.pc_en), (i == 5) ? 32'd0 : 32'd1);
            chk($sformatf("basic_load_off_%0d", i), 32'(if_a.pc_load), 32'd0);
        end
        tick();
        r_halt = 1'b0;
        #1;
        chk("basic_done",    32'(if_a.done),      32'd1);
        chk("basic_busy0",   32'(if_a.busy),      32'd0);
        chk("basic_en0",     32'(if_a.pc_en),     32'd0);
        chk("basic_cycles",  32'(if_a.cycles),    32'd5);
        chk("basic_tmo",     32'(if_a.timeout),   32'd0);
        chk("basic_tgt0",    32'(if_a.pc_target), 32'd0);
        tick();
        r_req = 1'b0;
        #1;
        chk("basic_done_hold", 32'(if_a.done), 32'd1);
        tick(); #1;
        chk("basic_done_drop", 32'(if_a.done), 32'd0);

        // ---------------- bad select ----------------
        bad_cnt = 0; stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            r_sel = 2'd3; r_req = (i < 3);
            #1;
            chk($sformatf("bad_sel_%0d", i), 32'(if_a.bad_sel), (i >= 1 && i <= 3) ? 32'd1 : 32'd0);
            if (if_a.bad_sel) bad_cnt++;
            if (if_a.pc_load || if_a.done || if_a.busy) stray = 1'b1;
        end
        chk("bad_pulses", 32'(bad_cnt), 32'd3);
        chk("bad_no_run", 32'(stray),   32'd0);

        // ---------------- timeout (TIMEOUT=8) ----------------
        do_reset();
        launch(2'd0);
        chk("tmo_pc_load", 32'(if_b.pc_load),   32'd1);
        chk("tmo_target",  32'(if_b.pc_target), 32'd0);
        run_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(); #1;
            if (if_b.done) begin
                seen = 1'b1;
                break;
            end
            if (if_b.pc_en) run_cnt++;
        end
        chk("tmo_done_seen", 32'(seen),         32'd1);
        chk("tmo_run_cnt",   32'(run_cnt),      32'd8);
        chk("tmo_flag",      32'(if_b.timeout), 32'd1);
        chk("tmo_cycles",    32'(if_b.cycles),  32'd8);
        tick();
        r_req = 1'b0;
        #1;
        launch(2'd0);
        tick(); #1;
        chk("tmo2_cleared", 32'(if_b.timeout), 32'd0);
        tick();
        r_halt = 1'b1;
        #1;
        tick();
        r_halt = 1'b0;
        #1;
        chk("tmo2_done",    32'(if_b.done),    32'd1);
        chk("tmo2_flag",    32'(if_b.timeout), 32'd0);
        chk("tmo2_cycles",  32'(if_b.cycles),  32'd2);

        // ---------------- halt / timeout tie (TIMEOUT=4) ----------------
        do_reset();
        launch(2'd2);
        chk("tie_target", 32'(if_c.pc_target), 32'h200);
        run_halt(4);
        chk("tie_done",    32'(if_c.done),    32'd1);
        chk("tie_flag",    32'(if_c.timeout), 32'd0);
        chk("tie_cycles",  32'(if_c.cycles),  32'd4);

        // ---------------- reset mid-run ----------------
        do_reset();
        launch(2'd1);
        tick(); #1;
        tick(); #1;
        tick();
        r_reset = 1'b1; r_req = 1'b0;
        #1;
        chk("mid_in_run", 32'(if_a.busy), 32'd1);
        tick();
        r_reset = 1'b0;
        #1;
        chk("mid_busy",   32'(if_a.busy),   32'd0);
        chk("mid_pc_en",  32'(if_a.pc_en),  32'd0);
        chk("mid_done",   32'(if_a.done),   32'd0);
        chk("mid_cycles", 32'(if_a.cycles), 32'd0);
        tick(); #1;
        chk("mid_no_done", 32'(if_a.done), 32'd0);
        launch(2'd2);
        chk("mid_relaunch",  32'(if_a.pc_load),   32'd1);
        chk("mid_re_target", 32'(if_a.pc_target), 32'h200);

        // ---------------- saturation and handshake (W_CYC=3) ----------------
        do_reset();
        launch(2'd0);
        run_halt(10);
        chk("sat_done",   32'(if_d.done),   32'd1);
        chk("sat_cycles", 32'(if_d.cycles), 32'd7);
        stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            if (!if_d.done || if_d.pc_load || if_d.busy) stray = 1'b1;
        end
        chk("hs_held", 32'(stray), 32'd0);
        tick();
        r_req = 1'b0;
        #1;
        chk("hs_done_still", 32'(if_d.done), 32'd1);
        tick();
        r_req = 1'b1;
        #1;
        chk("hs_done_low", 32'(if_d.done),    32'd0);
        chk("hs_idle",     32'(if_d.pc_load), 32'd0);
        tick(); #1;
        chk("hs_new_run",  32'(if_d.pc_load), 32'd1);
        chk("hs_cyc_clr",  32'(if_d.cycles),  32'd7);
        tick(); #1;
        chk("hs_cyc_zero", 32'(if_d.cycles),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
